// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: produces diff = a - b, DIGIT bits per clock, LSB
// first, with one borrow register carried between digit steps. Operands enter
// through a valid/ready handshake. Result and compare flags (borrow, zero,
// signed overflow) leave through a second valid/ready handshake.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    // Operands must split into whole digits; anything else is a build error
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParam
        $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  aShift_q;
    logic [WIDTH-1:0]  bShift_q;
    logic [WIDTH-1:0]  diff_q;
    logic              borrowRun_q;
    logic              borrowFlag_q;
    logic              zero_q;
    logic              ovf_q;
    logic              aMsb_q;
    logic              bMsb_q;
    logic [CW-1:0]     count_q;

    logic [DIGIT:0]    stepRes;
    logic [DIGIT-1:0]  digitDiff;
    logic              stepBorrow;
    logic [WIDTH-1:0]  diffShifted;
    logic              lastStep;

    // One digit of subtraction on the low digits of the shift registers, and
    // the diff register as it will look after this step's insertion at the top
    always_comb begin
        stepRes     = {1'b0, aShift_q[DIGIT-1:0]} - {1'b0, bShift_q[DIGIT-1:0]}
                      - {{DIGIT{1'b0}}, borrowRun_q};
        digitDiff   = stepRes[DIGIT-1:0];
        stepBorrow  = stepRes[DIGIT];
        diffShifted = diff_q >> DIGIT;
        diffShifted[WIDTH-1 -: DIGIT] = digitDiff;
        lastStep    = (count_q == LAST_STEP);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, run STEPS digits, hold in DONE until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i)  state_d = RUN;
            RUN:     if (lastStep)    state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
    end

    // Datapath: load operands on accept, shift one digit per RUN cycle, and
    // capture the flags from the completed difference on the final step so
    // they stay untouched until the next result is ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aShift_q     <= '0;
            bShift_q     <= '0;
            diff_q       <= '0;
            borrowRun_q  <= 1'b0;
            borrowFlag_q <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
            aMsb_q       <= 1'b0;
            bMsb_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        aShift_q    <= a_i;
                        bShift_q    <= b_i;
                        aMsb_q      <= a_i[WIDTH-1];
                        bMsb_q      <= b_i[WIDTH-1];
                        borrowRun_q <= 1'b0;
                        count_q     <= '0;
                    end
                end
                RUN: begin
                    aShift_q    <= aShift_q >> DIGIT;
                    bShift_q    <= bShift_q >> DIGIT;
                    diff_q      <= diffShifted;
                    borrowRun_q <= stepBorrow;
                    count_q     <= count_q + CW'(1);
                    if (lastStep) begin
                        borrowFlag_q <= stepBorrow;
                        zero_q       <= (diffShifted == '0);
                        ovf_q        <= (aMsb_q != bMsb_q) && (diffShifted[WIDTH-1] != aMsb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff_o   = diff_q;
    assign borrow_o = borrowFlag_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle unsigned/two's-complement subtractor: computes diff = a - b, DIGIT bits per clock, LSB first, with a single borrow register carried between steps.
- Companion to the combinational ripple adder in the datapath: it trades latency for area and adds flag outputs for compare/branch logic.
- Input side uses a valid/ready handshake; output side uses a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. Must satisfy DIGIT >= 1 and WIDTH % DIGIT == 0; elaboration fails otherwise.
- STEPS (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result valid; equals (state == DONE).
- out_ready  in  1  consumer takes result.
- diff  out  WIDTH  a - b mod 2^WIDTH.
- borrow  out  1  final borrow-out; 1 iff a < b (unsigned).
- zero  out  1  diff == 0; 1 iff a == b.
- ovf  out  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; diff = 0; borrow = 0; zero = 0; ovf = 0; step counter = 0. This gives out_valid = 0 and in_ready = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept when in_valid && in_ready at a rising edge.
  - On accept: latch a into shift register A and b into shift register B; latch a[MSB] and b[MSB] for ovf; set borrow reg = 0 and count = 0; go to RUN.
- RUN, each cycle:
  - {bout, d[DIGIT-1:0]} = {1'b0, A[DIGIT-1:0]} - {1'b0, B[DIGIT-1:0]} - borrow_reg.
  - The diff register shifts right by DIGIT, and d is inserted at bits [WIDTH-1 : WIDTH-DIGIT].
  - A and B shift right by DIGIT; borrow_reg <= bout; count++.
  - When count == STEPS-1, the current edge is the final step; go to DONE.
- DONE:
  - diff, borrow, zero and ovf are registered and held stable while out_valid = 1.
  - zero and ovf are computed from the final diff on the DONE entry edge.
  - On out_valid && out_ready, go to IDLE. Outputs keep their values until the next DONE entry.
- Latency: out_valid rises exactly STEPS cycles after the accept edge (DIGIT=1: 32; DIGIT=4: 8).
- Throughput: with out_ready held high, a new accept is possible every STEPS+2 cycles.
- in_ready = 0 in RUN and DONE. in_valid is ignored there, and a, b may change freely.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- Intermediate diff contents during RUN are don't-care externally, because out_valid = 0.
- Reset mid-RUN or mid-DONE: the operation is abandoned with no out_valid pulse. After rst_n deasserts, the block is in IDLE with in_ready = 1.
- Boundary cases:
  - a == b gives zero = 1, borrow = 0.
  - a = 0, b = 2^WIDTH-1 gives diff = 1, borrow = 1.
  - Wrap-around is modulo 2^WIDTH; there is no saturation.

Test Plan:
1. DIGIT=1, a=5, b=3, out_ready=1 -> out_valid exactly 32 cycles after accept; diff=0x00000002, borrow=0, zero=0, ovf=0; in_ready back to 1 one cycle after the out handshake.
2. a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, zero=0, ovf=0. a=0, b=0xFFFFFFFF -> diff=0x00000001, borrow=1.
3. Flags:
   - a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, ovf=1.
   - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow=1.
   - a=b=0x12345678 -> diff=0, zero=1, ovf=0.
4. Backpressure: result ready, out_ready=0 for 10 cycles, in_valid pulsed with new operands -> outputs stable, in_ready=0, new operands ignored. Then out_ready=1 -> handshake; the next accept is the operands presented in IDLE.
5. Reset: assert rst_n low asynchronously 10 cycles into RUN -> out_valid never rises, all outputs 0 immediately, in_ready=1 after release. Then 100-1=99 completes correctly.
6. DIGIT=4, WIDTH=32: latency 8. 1000 random back-to-back ops with random out_ready -> every diff/borrow/zero/ovf matches the model. With out_ready=1, accept spacing is exactly 10 cycles.
